// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the multi-cycle control unit.
//   state_t      - sequencer states
//   OP_*         - opcode encodings (8..15 are undefined)
//   *_LSB        - instruction field positions: opcode [3:0], dst [5:4], src [7:6]
//   REG_PC       - register index of the program counter
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MOV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 4;
  localparam int DST_LSB = 4;
  localparam int SRC_LSB = 6;
  localparam int REG_W   = 2;

  localparam logic [REG_W-1:0] REG_PC = 2'd0;

  // Opcodes 1..7 produce a register write.
  function automatic logic op_writes(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_INC);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for the sequencer.
//   opcode  - instruction opcode
//   a, b    - dst / src operands
//   c_in    - current carry flag, passed through by opcodes that keep C
//   result  - ALU result (modulo 2^DATA_W)
//   z       - result == 0
//   c       - next carry/borrow flag
//   writes  - opcode writes a register
//   illegal - opcode is undefined
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              writes,
  output logic              illegal
);

  logic [DATA_W:0] ext;

  always_comb begin
    ext     = '0;
    result  = '0;
    c       = c_in;
    writes  = op_writes(opcode);
    illegal = (opcode > OP_INC);
    case (opcode)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[DATA_W-1:0];
        c      = ext[DATA_W];
      end
      OP_SUB: begin
        // The extra bit of the difference is set exactly when b > a.
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[DATA_W-1:0];
        c      = ext[DATA_W];
      end
      OP_MOV: result = b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_INC: begin
        ext    = {1'b0, a} + (DATA_W+1)'(1);
        result = ext[DATA_W-1:0];
        c      = ext[DATA_W];
      end
      default: result = '0;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control unit for the 4 x 8-bit register datapath.
//   step       - single-cycle start pulse, accepted only in IDLE
//   run        - auto-issue enable (only when CPU_SEQ_AUTORUN_EN is defined)
//   instr      - instruction word, latched at the end of FETCH
//   pc         - current r0 value; presented on imem_addr during FETCH
//   rd_*_sel   - register read selects, valid in DECODE
//   rd_*_data  - register read data, latched at the end of DECODE
//   wr_*       - register write port, strobed in WRITEBACK
//   pc_inc     - r0 increment strobe in WRITEBACK (suppressed on a jump)
//   busy/done/illegal, flag_z/flag_c - status
// All outputs are flops; nothing combinational reaches an output.
//
// state     | meaning
// IDLE      | waiting for step (or auto-issue)
// FETCH     | imem_addr = pc, instruction latched
// DECODE    | read selects driven, operands latched
// EXECUTE   | ALU evaluates, writeback outputs registered
// WRITEBACK | done, write / pc_inc strobes
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 8
`ifdef CPU_SEQ_AUTORUN_EN
 ,parameter int RUN_GAP = 4
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
`ifdef CPU_SEQ_AUTORUN_EN
  input  logic               run,
`endif
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  pc,
  output logic [DATA_W-1:0]  imem_addr,
  output logic [REG_W-1:0]   rd_a_sel,
  output logic [REG_W-1:0]   rd_b_sel,
  input  logic [DATA_W-1:0]  rd_a_data,
  input  logic [DATA_W-1:0]  rd_b_data,
  output logic               wr_en,
  output logic [REG_W-1:0]   wr_sel,
  output logic [DATA_W-1:0]  wr_data,
  output logic               pc_inc,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               flag_z,
  output logic               flag_c
);

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [REG_W-1:0]    dst_q, dst_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   imem_addr_q, imem_addr_d;
  logic [REG_W-1:0]    rd_a_sel_q, rd_a_sel_d, rd_b_sel_q, rd_b_sel_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_W-1:0]    wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                pc_inc_q, pc_inc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_z, alu_c, alu_writes, alu_illegal;

`ifdef CPU_SEQ_AUTORUN_EN
  localparam int GAP_W = (RUN_GAP > 1) ? $clog2(RUN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RUN_GAP - 1);
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                halt_q, halt_d;
  logic                auto_go;
`endif

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode  (opc_q),
    .a       (a_q),
    .b       (b_q),
    .c_in    (flag_c_q),
    .result  (alu_result),
    .z       (alu_z),
    .c       (alu_c),
    .writes  (alu_writes),
    .illegal (alu_illegal)
  );

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    dst_d       = dst_q;
    a_d         = a_q;
    b_d         = b_q;
    imem_addr_d = '0;
    rd_a_sel_d  = '0;
    rd_b_sel_d  = '0;
    wr_en_d     = 1'b0;
    wr_sel_d    = '0;
    wr_data_d   = '0;
    pc_inc_d    = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
`ifdef CPU_SEQ_AUTORUN_EN
    gap_d       = gap_q;
    halt_d      = halt_q;
    auto_go     = 1'b0;
    // Dropping run is the only way out of an illegal-opcode halt.
    if (!run) halt_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef CPU_SEQ_AUTORUN_EN
        if (!run) begin
          gap_d = GAP_LOAD;
        end else if (!halt_q) begin
          if (gap_q == '0) auto_go = 1'b1;
          else             gap_d   = gap_q - 1'b1;
        end
        if (step || auto_go) begin
`else
        if (step) begin
`endif
          state_d     = FETCH;
          // pc is stable until the WRITEBACK of this instruction.
          imem_addr_d = pc;
        end
      end
      FETCH: begin
        opc_d      = instr[OPC_LSB +: OPC_W];
        dst_d      = instr[DST_LSB +: REG_W];
        rd_a_sel_d = instr[DST_LSB +: REG_W];
        rd_b_sel_d = instr[SRC_LSB +: REG_W];
        state_d    = DECODE;
      end
      DECODE: begin
        a_d     = rd_a_data;
        b_d     = rd_b_data;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        done_d    = 1'b1;
        illegal_d = alu_illegal;
        wr_en_d   = alu_writes;
        if (alu_writes) begin
          wr_sel_d  = dst_q;
          wr_data_d = alu_result;
          flag_z_d  = alu_z;
        end
        // A write to r0 is a jump, so the increment must not also fire.
        pc_inc_d  = !(alu_writes && (dst_q == REG_PC));
        flag_c_d  = alu_c;
`ifdef CPU_SEQ_AUTORUN_EN
        if (alu_illegal) halt_d = 1'b1;
`endif
        state_d   = WRITEBACK;
      end
      WRITEBACK: begin
`ifdef CPU_SEQ_AUTORUN_EN
        gap_d   = GAP_LOAD;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opc_q       <= '0;
      dst_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imem_addr_q <= '0;
      rd_a_sel_q  <= '0;
      rd_b_sel_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= '0;
      wr_data_q   <= '0;
      pc_inc_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
`ifdef CPU_SEQ_AUTORUN_EN
      gap_q       <= GAP_LOAD;
      halt_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      dst_q       <= dst_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imem_addr_q <= imem_addr_d;
      rd_a_sel_q  <= rd_a_sel_d;
      rd_b_sel_q  <= rd_b_sel_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
      pc_inc_q    <= pc_inc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
`ifdef CPU_SEQ_AUTORUN_EN
      gap_q       <= gap_d;
      halt_q      <= halt_d;
`endif
    end
  end

  assign imem_addr = imem_addr_q;
  assign rd_a_sel  = rd_a_sel_q;
  assign rd_b_sel  = rd_b_sel_q;
  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_data   = wr_data_q;
  assign pc_inc    = pc_inc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign illegal   = illegal_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control unit for the 4 x 8-bit register datapath (r0 = program counter, r1..r3 general, r3 drives LEDs).
- Accepts a single-cycle step pulse from the debounced button and sequences fetch, decode, execute and writeback.
- Drives register-file read selects and the write port, computes the result in an internal ALU, and holds Z/C flags.
- Sits between the button/DIP input logic and the external register file.

Parameters:
DATA_W, 8, register/ALU data width
INSTR_W, 8, instruction width; fields: opcode [3:0], dst [5:4], src [7:6]
RUN_GAP, 4, IDLE cycles between auto-issued instructions (only used with CPU_SEQ_AUTORUN_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
step  input  1  single-cycle start pulse (debounced button)
instr  input  INSTR_W  instruction word, sampled in FETCH
pc  input  DATA_W  current r0 value from register file
imem_addr  output  DATA_W  instruction address, equals pc during FETCH, else 0
rd_a_sel  output  2  read port A select (dst operand)
rd_b_sel  output  2  read port B select (src operand)
rd_a_data  input  DATA_W  combinational read data A
rd_b_data  input  DATA_W  combinational read data B
wr_en  output  1  register write strobe, one cycle
wr_sel  output  2  register write address
wr_data  output  DATA_W  register write data
pc_inc  output  1  one-cycle strobe: register file increments r0 (wraps 0xFF -> 0x00)
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse in WRITEBACK
illegal  output  1  one-cycle pulse with done when the opcode is undefined
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag

Behaviour:
- Reset: asynchronous on rst_n low.
  - State returns to IDLE; the instruction register, operands, result and flags clear.
  - All outputs are 0; no write or pc_inc is issued even if reset arrives mid-instruction.
- States: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> IDLE, one cycle each. Latency is 4 cycles from the step-accept edge to done.
- IDLE: step=1 is accepted and the next state is FETCH. A step pulse in any other state is ignored, not queued.
- FETCH: imem_addr = pc; instr is latched at the end of the cycle.
- DECODE: rd_a_sel = dst, rd_b_sel = src; rd_a_data and rd_b_data are latched.
- EXECUTE: internal ALU computes the result and next flags from the latched operands.
- Opcodes (A = dst operand, B = src operand):
  - 0 NOP: no write.
  - 1 ADD: A+B. C = carry-out.
  - 2 SUB: A-B. C = borrow (1 when B>A).
  - 3 MOV: B.
  - 4 AND: A&B.
  - 5 OR: A|B.
  - 6 XOR: A^B.
  - 7 INC: A+1. C = carry-out.
  - 8..15: illegal, no write, flags unchanged.
- Flags:
  - Arithmetic is modulo 2^DATA_W.
  - Z = (result==0); updated for every opcode that writes.
  - C is updated only by ADD, SUB and INC; other opcodes leave it unchanged.
- WRITEBACK:
  - done=1. wr_en=1 for opcodes 1..7, with wr_sel = dst and wr_data = result.
  - If dst != 0 or no write occurs: pc_inc=1.
  - If a write targets r0 (dst==0): pc_inc=0. The write acts as a jump; wr_en and pc_inc are never both asserted for r0.
  - Illegal opcode: illegal=1 together with done, pc_inc=1.
- Outputs are registered or decoded from the state only; there are no combinational paths from inputs to outputs.

Optional Feature:
CPU_SEQ_AUTORUN_EN
- Defined:
  - Adds input port run (1 bit).
  - While run=1, the sequencer leaves IDLE by itself after RUN_GAP IDLE cycles, with no step pulse needed; step is still accepted in IDLE.
  - An illegal opcode forces a halt: auto-issue stops until run is deasserted and reasserted.
  - run=0 behaves exactly like the macro undefined.
- Undefined: no run port; execution only on step.

Decomposition:
- Package cpu_pkg:
  - state enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK)
  - opcode constants OP_NOP..OP_INC
  - instruction field bit positions
  - register index constants (REG_PC=0)
- Sub-module cpu_alu: combinational; inputs opcode, a, b, c_in; outputs result, z, c, writes, illegal.

Test Plan:
- r1=0x05, r2=0x03, instr ADD dst=1 src=2, one step -> done 4 cycles after accept; wr_sel=1, wr_data=0x08, Z=0, C=0, pc_inc=1.
- r1=0x02, r2=0x03, SUB dst=1 src=2 -> wr_data=0xFF, C=1, Z=0; then r1=0x03, r2=0x03, SUB dst=1 src=2 -> wr_data=0x00, Z=1, C=0.
- r3=0xFF, INC dst=3 -> wr_data=0x00, Z=1, C=1; then AND -> C stays 1.
- MOV dst=0 src=1 with r1=0x40 -> wr_en=1, wr_sel=0, wr_data=0x40, pc_inc=0; opcode 0xF -> illegal=1, wr_en=0, pc_inc=1, flags unchanged.
- Step pulses in FETCH..WRITEBACK -> ignored (exactly one done); rst_n low during EXECUTE -> no wr_en, busy=0 immediately, next step runs normally.
- With CPU_SEQ_AUTORUN_EN, RUN_GAP=4, run=1, program of NOPs -> done every 8 cycles; illegal opcode -> halts until run toggles 1->0->1.
